// File: rtl/execute_pkg.sv
// Shared definitions for the decode/execute pipeline: ALU operation codes
// and the single-cycle ALU function.
package execute_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned CTR_W  = 3;

  localparam logic [CTR_W-1:0] ALU_ADD = 3'd0;
  localparam logic [CTR_W-1:0] ALU_SUB = 3'd1;
  localparam logic [CTR_W-1:0] ALU_SLT = 3'd2;
  localparam logic [CTR_W-1:0] ALU_MUL = 3'd3;

  // Single-cycle ALU result. The multiply and unsupported codes yield zero;
  // the multiply result comes from the iterative unit instead.
  function automatic logic [DATA_W-1:0] alu_result(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [CTR_W-1:0]  ctr
  );
    logic [DATA_W-1:0] res;
    res = '0;
    case (ctr)
      ALU_ADD: res = a + b;
      ALU_SUB: res = a - b;
      ALU_SLT: res = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/execute_mul_iter.sv
// Iterative shift-add multiplier: one partial-product step per cycle,
// 32 steps, low 32 bits of the unsigned product.
module mul_iter
  import execute_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [4:0]        step;

  // The edge that completes step 32 is the one where step==31; the final
  // partial product is folded in combinationally so the caller can register
  // the finished product on that same edge.
  assign done    = busy && (step == 5'd31);
  assign product = mplier[0] ? (acc + mcand) : acc;

  // Operand capture and one shift-add step per cycle while running.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: these are plain registers, not a memory, so they reset cleanly;
      // every sequential assignment is non-blocking to avoid race ordering.
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      step   <= '0;
      busy   <= 1'b0;
    end else if (start && !busy) begin
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
      step   <= '0;
      busy   <= 1'b1;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      step   <= step + 5'd1;
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/execute.sv
// Execute stage: single-cycle add/sub/slt/lw address, plus an optional
// 32-cycle iterative multiply that stalls upstream through busy.
module execute
  import execute_pkg::*;
#(
  parameter int unsigned MUL_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [REG_W-1:0]  RD,
  input  logic [CTR_W-1:0]  ALUctr,
  input  logic              DX_lwFlag,
  output logic [DATA_W-1:0] XM_ALUout,
  output logic [REG_W-1:0]  XM_RD,
  output logic              XM_lwFlag,
  output logic              busy
);

  typedef enum logic {IDLE, MUL} state_e;

  state_e            state, state_n;
  logic [DATA_W-1:0] alu_n;
  logic [REG_W-1:0]  rd_n;
  logic              lw_n;
  logic [REG_W-1:0]  cap_rd, cap_rd_n;
  logic              cap_lw, cap_lw_n;
  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic [DATA_W-1:0] mul_product;

  assign busy = (state == MUL);

  generate
    if (MUL_EN != 0) begin : g_mul
      mul_iter u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_busy    = 1'b0;
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  // Next-state and next-output decode for the IDLE/MUL controller.
  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_n   = state;
    alu_n     = XM_ALUout;
    rd_n      = XM_RD;
    lw_n      = XM_lwFlag;
    cap_rd_n  = cap_rd;
    cap_lw_n  = cap_lw;
    mul_start = 1'b0;
    case (state)
      IDLE: begin
        if ((MUL_EN != 0) && (ALUctr == ALU_MUL) && (RD != '0)) begin
          mul_start = 1'b1;
          state_n   = MUL;
          rd_n      = '0;
          lw_n      = 1'b0;
          cap_rd_n  = RD;
          cap_lw_n  = DX_lwFlag;
        end else begin
          alu_n = alu_result(A, B, ALUctr);
          rd_n  = RD;
          lw_n  = DX_lwFlag;
        end
      end
      MUL: begin
        rd_n = '0;
        if (mul_done) begin
          alu_n   = mul_product;
          rd_n    = cap_rd;
          lw_n    = cap_lw;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, pipeline outputs and captured destination/lw flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      XM_ALUout <= '0;
      XM_RD     <= '0;
      XM_lwFlag <= 1'b0;
      cap_rd    <= '0;
      cap_lw    <= 1'b0;
    end else begin
      state     <= state_n;
      XM_ALUout <= alu_n;
      XM_RD     <= rd_n;
      XM_lwFlag <= lw_n;
      cap_rd    <= cap_rd_n;
      cap_lw    <= cap_lw_n;
    end
  end

  // The controller and the multiplier must agree on whether a multiply runs.
  a_busy_sync : assert property (@(posedge clk) disable iff (!rst)
    (MUL_EN == 0) || (busy == mul_busy));

endmodule

// File: tb/tb_execute.sv
// Self-checking bench for execute: directed cases plus randomized
// instructions compared against an arithmetic reference model.
module tb_execute;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  RD;
  logic [2:0]  ALUctr;
  logic        DX_lwFlag;
  logic [31:0] XM_ALUout;
  logic [4:0]  XM_RD;
  logic        XM_lwFlag;
  logic        busy;

  int checks;
  int failures;

  execute #(.MUL_EN(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .RD        (RD),
    .ALUctr    (ALUctr),
    .DX_lwFlag (DX_lwFlag),
    .XM_ALUout (XM_ALUout),
    .XM_RD     (XM_RD),
    .XM_lwFlag (XM_lwFlag),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: result of a non-multiply instruction from the ISA rules.
  function automatic logic [31:0] model_single(input logic [31:0] a, input logic [31:0] b,
                                               input logic [2:0] ctr);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (ctr)
      3'd0:    return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      3'd1:    return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
      3'd2:    return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return p[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input logic [2:0] ctr, input logic lw);
    A = a; B = b; RD = rd; ALUctr = ctr; DX_lwFlag = lw;
  endtask

  // One single-cycle instruction, checked one edge later.
  task automatic run_single(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, input logic [2:0] ctr, input logic lw);
    logic [31:0] exp_alu;
    exp_alu = model_single(a, b, ctr);
    drive(a, b, rd, ctr, lw);
    step();
    checks++;
    if (XM_ALUout !== exp_alu) begin
      failures++;
      $display("FAIL %s alu: got %h expected %h", name, XM_ALUout, exp_alu);
    end
    checks++;
    if (XM_RD !== rd) begin
      failures++;
      $display("FAIL %s rd: got %0d expected %0d", name, XM_RD, rd);
    end
    checks++;
    if (XM_lwFlag !== lw) begin
      failures++;
      $display("FAIL %s lw: got %b expected %b", name, XM_lwFlag, lw);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s busy: got %b expected 0", name, busy);
    end
  endtask

  // One multiply: checks the stall window and the final result, then leaves
  // a bubble on the inputs (callers may overwrite it immediately).
  task automatic run_mul(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic lw);
    logic [31:0] prev;
    logic [31:0] exp_p;
    int          n;
    bit          bad;
    prev  = XM_ALUout;
    exp_p = model_mul(a, b);
    drive(a, b, rd, 3'd3, lw);
    step();
    checks++;
    if (busy !== 1'b1 || XM_RD !== 5'd0) begin
      failures++;
      $display("FAIL %s capture: busy=%b rd=%0d expected busy=1 rd=0", name, busy, XM_RD);
    end
    n   = 0;
    bad = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      step();
      n++;
      if (busy === 1'b1 && (XM_RD !== 5'd0 || XM_ALUout !== prev)) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL %s stall_hold: rd or alu changed while busy, alu=%h expected %h", name, XM_ALUout, prev);
    end
    checks++;
    if (n != 32) begin
      failures++;
      $display("FAIL %s latency: got %0d edges expected 32", name, n);
    end
    checks++;
    if (XM_ALUout !== exp_p) begin
      failures++;
      $display("FAIL %s product: got %h expected %h", name, XM_ALUout, exp_p);
    end
    checks++;
    if (XM_RD !== rd || XM_lwFlag !== lw || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s result_ctl: rd=%0d lw=%b busy=%b expected rd=%0d lw=%b busy=0",
               name, XM_RD, XM_lwFlag, busy, rd, lw);
    end
    drive('0, '0, '0, 3'd0, 1'b0);
  endtask

  task automatic test_reset();
    drive('0, '0, '0, 3'd0, 1'b0);
    rst = 1'b0;
    #22;
    checks++;
    if (XM_ALUout !== 32'd0 || XM_RD !== 5'd0 || XM_lwFlag !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: alu=%h rd=%0d lw=%b busy=%b expected all 0",
               XM_ALUout, XM_RD, XM_lwFlag, busy);
    end
    step();
    rst = 1'b1;
  endtask

  task automatic test_alu();
    run_single("add_wrap", 32'h7FFFFFFF, 32'd1, 5'd5, 3'd0, 1'b0);
    checks++;
    if (XM_ALUout !== 32'h80000000) begin
      failures++;
      $display("FAIL add_const: got %h expected 80000000", XM_ALUout);
    end
    run_single("sub_neg", 32'd3, 32'd5, 5'd6, 3'd1, 1'b0);
    checks++;
    if (XM_ALUout !== 32'hFFFFFFFE) begin
      failures++;
      $display("FAIL sub_const: got %h expected fffffffe", XM_ALUout);
    end
    run_single("slt_signed", 32'hFFFFFFFF, 32'd1, 5'd7, 3'd2, 1'b0);
    checks++;
    if (XM_ALUout !== 32'd1) begin
      failures++;
      $display("FAIL slt_const: got %h expected 1", XM_ALUout);
    end
    run_single("slt_false", 32'd1, 32'hFFFFFFFF, 5'd7, 3'd2, 1'b0);
    run_single("add_full_wrap", 32'hFFFFFFFF, 32'd2, 5'd1, 3'd0, 1'b0);
    run_single("unsupported", 32'h1234, 32'h5678, 5'd12, 3'd6, 1'b1);
  endtask

  task automatic test_lw();
    run_single("lw", 32'h100, 32'h4, 5'd8, 3'd0, 1'b1);
    checks++;
    if (XM_ALUout !== 32'h104 || XM_lwFlag !== 1'b1) begin
      failures++;
      $display("FAIL lw_const: alu=%h lw=%b expected 104 / 1", XM_ALUout, XM_lwFlag);
    end
  endtask

  task automatic test_mul();
    run_mul("mul_basic", 32'd1234, 32'd5678, 5'd9, 1'b0);
    checks++;
    if (XM_ALUout !== 32'd7006652) begin
      failures++;
      $display("FAIL mul_const: got %0d expected 7006652", XM_ALUout);
    end
    run_mul("mul_neg", 32'hFFFFFFFD, 32'd7, 5'd3, 1'b1);
    run_single("after_mul", 32'd10, 32'd20, 5'd4, 3'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_mul("b2b_first", 32'hDEADBEEF, 32'h12345, 5'd10, 1'b0);
    run_mul("b2b_second", 32'h0BADF00D, 32'hFFFF0001, 5'd11, 1'b0);
    run_single("b2b_follow", 32'd5, 32'd9, 5'd2, 3'd2, 1'b0);
  endtask

  task automatic test_reset_mid_mul();
    bit bad;
    drive(32'd1234, 32'd5678, 5'd9, 3'd3, 1'b0);
    step();
    repeat (10) step();
    rst = 1'b0;
    #1;
    checks++;
    if (XM_ALUout !== 32'd0 || XM_RD !== 5'd0 || XM_lwFlag !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: alu=%h rd=%0d lw=%b busy=%b expected all 0",
               XM_ALUout, XM_RD, XM_lwFlag, busy);
    end
    drive('0, '0, '0, 3'd0, 1'b0);
    step();
    step();
    rst = 1'b1;
    run_single("post_reset_add", 32'd100, 32'd23, 5'd14, 3'd0, 1'b0);
    bad = 1'b0;
    drive('0, '0, '0, 3'd0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step();
      if (XM_RD !== 5'd0 || XM_ALUout !== 32'd0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL stale_result: rd=%0d alu=%h busy=%b expected 0", XM_RD, XM_ALUout, busy);
    end
  endtask

  task automatic test_bubble_mul();
    run_single("bubble_mul", 32'd77, 32'd88, 5'd0, 3'd3, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic [2:0]  ctr;
    logic        lw;
    for (int i = 0; i < 150; i++) begin
      a   = $urandom;
      b   = $urandom;
      ctr = 3'($urandom_range(0, 7));
      rd  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lw  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 32'h80000000 | a;
      if (ctr == 3'd3 && rd != 5'd0) run_mul("rand_mul", a, b, rd, lw);
      else run_single("rand_single", a, b, rd, ctr, lw);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_alu();
    test_lw();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_bubble_mul();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/execute.md
EXECUTE -- requirements
Module: execute

Interface
REQ-001 The block SHALL expose parameter MUL_EN, default 1, meaning the iterative multiply op is implemented (0: ALUctr=3 treated as unsupported).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 A  input  32  operand A from the decode stage.
REQ-006 B  input  32  operand B from the decode stage (register value or lw offset).
REQ-007 RD  input  5  destination register; 0 = bubble, no writeback.
REQ-008 ALUctr  input  3  operation: 0 add, 1 sub, 2 slt, 3 mul, 4-7 unsupported.
REQ-009 DX_lwFlag  input  1  instruction is lw.
REQ-010 XM_ALUout  output  32  registered ALU result or lw address.
REQ-011 XM_RD  output  5  registered destination register; 0 during multiply busy and after reset.
REQ-012 XM_lwFlag  output  1  registered lw flag.
REQ-013 busy  output  1  multiply in progress; upstream holds A, B, RD, ALUctr and DX_lwFlag while high.

Function
REQ-014 The block SHALL have two states, IDLE and MUL; busy SHALL equal (state==MUL), decoded from the state register.
REQ-015 In IDLE with ALUctr in {0,1,2}, the block SHALL register the result, RD and DX_lwFlag at the next rising edge (1-cycle latency, one instruction per cycle).
REQ-016 Add and sub SHALL wrap modulo 2^32 with no overflow flag or exception.
REQ-017 slt SHALL compare A and B as signed two's-complement and produce 32'd1 if A<B, else 32'd0.
REQ-018 For lw (DX_lwFlag=1, ALUctr=0), XM_ALUout SHALL be A+B and XM_lwFlag SHALL be 1.
REQ-019 ALUctr 4-7, and ALUctr 3 with MUL_EN=0, SHALL produce XM_ALUout=0 and pass RD and DX_lwFlag through with 1-cycle latency.
REQ-020 In IDLE with ALUctr=3, RD!=0 and MUL_EN=1, the block SHALL capture A, B, RD and DX_lwFlag, clear the step counter, enter MUL, and drive XM_RD=0 at that edge.
REQ-021 In MUL, the block SHALL perform one shift-add step per cycle, 32 steps total, ignoring all inputs.
REQ-022 On the edge completing step 32, the block SHALL drive XM_ALUout with the low 32 bits of A*B (unsigned product, equal to the signed low word), restore the captured RD and lw flag, and return to IDLE.
REQ-023 Multiply latency SHALL be 32 edges from the capture edge to the result edge; busy SHALL be high for exactly 32 cycles.
REQ-024 During MUL, XM_RD SHALL stay 0 and XM_ALUout SHALL hold its last value.
REQ-025 A bubble (RD=0) with ALUctr=3 SHALL NOT start a multiply: 1-cycle pass-through, XM_ALUout=0, busy stays low.
REQ-026 On the cycle after the result edge, the block SHALL accept a new instruction, including a back-to-back multiply.

Reset
REQ-027 While rst is 0, the block SHALL asynchronously force XM_ALUout=0, XM_RD=0, XM_lwFlag=0, state=IDLE, step counter=0 and captured operands=0.
REQ-028 A reset asserted mid-multiply SHALL abort the operation with no result emitted; after release, the block SHALL accept a new instruction on the first rising edge.

Structure
REQ-029 ALUctr codes (ALU_ADD=0, ALU_SUB=1, ALU_SLT=2, ALU_MUL=3) SHALL live in the shared definitions package used by decode and execute.
REQ-030 The state encoding SHALL be local to execute.
REQ-031 The iterative multiplier SHALL be one sub-module, mul_iter, with start, busy, done and a 32-bit product.

Verification
REQ-032 Add: A=32'h7FFFFFFF, B=1, RD=5, ALUctr=0 -> next edge XM_ALUout=32'h80000000, XM_RD=5, XM_lwFlag=0.
REQ-033 Sub/slt: A=3, B=5, ALUctr=1 -> 32'hFFFFFFFE; then A=32'hFFFFFFFF (-1), B=1, ALUctr=2 -> XM_ALUout=1.
REQ-034 lw: A=32'h100, B=32'h0004, RD=8, DX_lwFlag=1, ALUctr=0 -> XM_ALUout=32'h104, XM_RD=8, XM_lwFlag=1.
REQ-035 Mul: A=32'd1234, B=32'd5678, RD=9, ALUctr=3 -> busy high 32 cycles with XM_RD=0 -> XM_ALUout=32'd7006652, XM_RD=9, busy low.
REQ-036 Back-to-back mul: second mul issued the cycle busy drops -> accepted immediately, second result 32 edges later.
REQ-037 Reset mid-mul: rst=0 at step 10 -> all outputs 0, state IDLE, no stale result after release; a following add completes normally.
REQ-038 Bubble mul: RD=0, ALUctr=3 -> busy stays 0, XM_RD=0 next edge.
